// File: rtl/gb_video_pkg.sv
// Shared video types and LCD geometry for the PPU pixel sink.
package gb_video_pkg;

  typedef enum logic [1:0] {
    H_BLANK = 2'd0,
    V_BLANK = 2'd1,
    SCAN    = 2'd2,
    DRAW    = 2'd3
  } PPU_STATES_t;

  typedef enum logic [2:0] {
    SINK_UNSYNC,
    SINK_WAIT_LINE,
    SINK_LINE,
    SINK_FLUSH,
    SINK_DRAIN
  } sink_state_t;

  localparam logic [7:0]  LCD_W             = 8'd160;
  localparam logic [7:0]  LCD_H             = 8'd144;
  localparam logic [12:0] FB_BYTES_PER_LINE = 13'd40;

  typedef struct packed {
    logic [12:0] addr;
    logic [7:0]  data;
  } fb_wr_t;

  // Left-justify a partial group of `fill` pixels, zero-padding the unused slots.
  function automatic logic [7:0] pad_byte(input logic [7:0] pack, input logic [1:0] fill);
    return pack << {3'd4 - {1'b0, fill}, 1'b0};
  endfunction

endpackage

// File: rtl/ppu_px_sink_fifo.sv
// Synchronous write buffer for packed framebuffer bytes; push on full is accepted when a pop
// happens in the same cycle.
module px_sink_fifo
  import gb_video_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  fb_wr_t push_data,
  input  logic   pop,
  output fb_wr_t head,
  output logic   full,
  output logic   empty
);

  localparam int AW = $clog2(DEPTH);

  fb_wr_t         mem [DEPTH];
  logic [AW:0]    wptr, rptr;
  logic           do_push, do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) begin
        mem[wptr[AW-1:0]] <= push_data;
        wptr              <= wptr + 1'b1;
      end
      if (do_pop) rptr <= rptr + 1'b1;
    end
  end

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign head  = mem[rptr[AW-1:0]];

endmodule

// File: rtl/ppu_px_sink.sv
// PPU pixel stream to 160x144 2bpp framebuffer writer. Define PX_PALETTE_EN to store BGP shades
// instead of raw colour indices.
//   state      | meaning
//   UNSYNC     | waiting for first V_BLANK, pixels ignored
//   WAIT_LINE  | between lines, waiting for DRAW
//   LINE       | accepting pixels for line y
//   FLUSH      | push padded partial byte, x=0
//   DRAIN      | frame ended, waiting for FIFO to empty
module ppu_px_sink
  import gb_video_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [12:0] FB_BASE    = 13'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  PX_OUT,
  input  logic        PX_valid,
  input  logic [1:0]  PPU_MODE,
  input  logic [7:0]  BGP,
  output logic        FB_WR,
  output logic [12:0] FB_ADDR,
  output logic [7:0]  FB_DATA,
  input  logic        FB_READY,
  output logic        FRAME_DONE,
  output logic        OVERFLOW
);

  sink_state_t state, state_nx;
  PPU_STATES_t mode, prev_mode;
  logic        vblank_enter, line_end;
  logic [7:0]  x, y, pack, pack_nx;
  logic [12:0] line_base, grp_addr;
  logic        frame_end_pend;
  logic [1:0]  px_st;
  logic        px_take, flush_cyc;
  logic        push, pop, full, empty;
  fb_wr_t      push_data, head;

`ifdef PX_PALETTE_EN
  assign px_st = BGP[{PX_OUT, 1'b1} -: 2];
`else
  logic unused_bgp;
  assign unused_bgp = ^BGP;
  assign px_st      = PX_OUT;
`endif

  assign mode         = PPU_STATES_t'(PPU_MODE);
  assign vblank_enter = (mode == V_BLANK) && (prev_mode != V_BLANK);
  assign line_end     = (prev_mode == DRAW) && (mode == H_BLANK);

  always_ff @(posedge clk) begin
    if (rst) state <= SINK_UNSYNC;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      SINK_UNSYNC:    if (vblank_enter) state_nx = SINK_WAIT_LINE;
      SINK_WAIT_LINE: if (vblank_enter)         state_nx = SINK_DRAIN;
                      else if (mode == DRAW)    state_nx = SINK_LINE;
      SINK_LINE:      if (vblank_enter || line_end) state_nx = SINK_FLUSH;
      SINK_FLUSH:     state_nx = frame_end_pend ? SINK_DRAIN : SINK_WAIT_LINE;
      SINK_DRAIN:     if (empty) state_nx = SINK_WAIT_LINE;
      default:        state_nx = SINK_UNSYNC;
    endcase
  end

  always_comb begin
    px_take    = (state == SINK_LINE) && PX_valid;
    flush_cyc  = (state == SINK_FLUSH);
    FRAME_DONE = (state == SINK_DRAIN) && empty;
  end

  assign pack_nx  = {pack[5:0], px_st};
  assign grp_addr = FB_BASE + line_base + {7'd0, x[7:2]};

  always_comb begin
    push      = 1'b0;
    push_data = '0;
    if (px_take && x < LCD_W && y < LCD_H && x[1:0] == 2'd3) begin
      push      = 1'b1;
      push_data = '{addr: grp_addr, data: pack_nx};
    end else if (flush_cyc && x[1:0] != 2'd0 && x < LCD_W && y < LCD_H) begin
      push      = 1'b1;
      push_data = '{addr: grp_addr, data: pad_byte(pack, x[1:0])};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_mode      <= H_BLANK;
      x              <= '0;
      y              <= '0;
      line_base      <= '0;
      pack           <= '0;
      frame_end_pend <= 1'b0;
      OVERFLOW       <= 1'b0;
    end else begin
      prev_mode <= mode;
      if (push && full && !pop) OVERFLOW <= 1'b1;
      case (state)
        SINK_LINE: begin
          frame_end_pend <= vblank_enter;
          if (px_take) begin
            pack <= pack_nx;
            if (x != 8'hFF) x <= x + 8'd1;
          end
        end
        SINK_FLUSH: begin
          x    <= '0;
          pack <= '0;
          // y saturates at LCD_H so surplus lines stay clipped until V_BLANK.
          if (!frame_end_pend && y < LCD_H) begin
            y         <= y + 8'd1;
            line_base <= line_base + FB_BYTES_PER_LINE;
          end
        end
        SINK_DRAIN: begin
          if (empty) begin
            y         <= '0;
            line_base <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  px_sink_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  assign FB_WR   = !empty;
  assign FB_ADDR = empty ? FB_BASE : head.addr;
  assign FB_DATA = empty ? 8'd0    : head.data;
  assign pop     = FB_WR && FB_READY;

endmodule

// File: tb/tb_ppu_px_sink.sv
// Bench for ppu_px_sink: table lines, hand sequences, and random lines vs a framebuffer model.
module tb_ppu_px_sink;

  logic        clk;
  logic        rst;
  logic [1:0]  PX_OUT;
  logic        PX_valid;
  logic [1:0]  PPU_MODE;
  logic [7:0]  BGP;
  logic        FB_WR;
  logic [12:0] FB_ADDR;
  logic [7:0]  FB_DATA;
  logic        FB_READY;
  logic        FRAME_DONE;
  logic        OVERFLOW;

  ppu_px_sink dut (
    .clk        (clk),
    .rst        (rst),
    .PX_OUT     (PX_OUT),
    .PX_valid   (PX_valid),
    .PPU_MODE   (PPU_MODE),
    .BGP        (BGP),
    .FB_WR      (FB_WR),
    .FB_ADDR    (FB_ADDR),
    .FB_DATA    (FB_DATA),
    .FB_READY   (FB_READY),
    .FRAME_DONE (FRAME_DONE),
    .OVERFLOW   (OVERFLOW)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [20:0] wq[$];
  logic [20:0] eq[$];
  int          fd_cnt = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (FB_WR && FB_READY) wq.push_back({FB_ADDR, FB_DATA});
      if (FRAME_DONE) fd_cnt++;
    end
  end

  logic [1:0] line_px [0:199];
  int         line_n;
  int         cur_y;
  bit         rdy_rand = 0;
  int         low_run  = 0;

  typedef struct {
    int         n;
    logic [7:0] pat;
    int         exp_n;
    int         exp_off;
    logic [7:0] exp_d;
  } vec_t;
  vec_t vt[9];

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    if (rdy_rand) begin
      if (low_run < 3 && $urandom_range(0, 3) == 0) begin
        FB_READY = 1'b0;
        low_run++;
      end else begin
        FB_READY = 1'b1;
        low_run  = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] shade(input logic [1:0] p, input logic [7:0] bgp);
    logic [7:0] pal;
    pal = bgp;
`ifndef PX_PALETTE_EN
    pal = 8'hE4;
`endif
    return 2'((pal >> (2 * p)) & 8'h03);
  endfunction

  // Expected writes for one line: byte b of row yy holds pixels 4b..4b+3, missing ones as 0.
  task automatic model_line(input int yy, input logic [7:0] bgp);
    logic [7:0] b8;
    eq.delete();
    if (yy < 144) begin
      for (int b = 0; b < 40; b++) begin
        if (4 * b >= line_n) break;
        b8 = 8'd0;
        for (int k = 0; k < 4; k++)
          if (4 * b + k < line_n) b8 = b8 | (8'(shade(line_px[4 * b + k], bgp)) << (6 - 2 * k));
        eq.push_back({13'(yy * 40 + b), b8});
      end
    end
  endtask

  task automatic check_writes(input string name);
    int n;
    cmp($sformatf("%s count y=%0d", name, cur_y), wq.size(), eq.size());
    n = (wq.size() < eq.size()) ? wq.size() : eq.size();
    for (int i = 0; i < n; i++) begin
      cmp($sformatf("%s addr y=%0d i=%0d", name, cur_y, i), 32'(wq[i][20:8]), 32'(eq[i][20:8]));
      cmp($sformatf("%s data y=%0d i=%0d", name, cur_y, i), 32'(wq[i][7:0]), 32'(eq[i][7:0]));
    end
    wq.delete();
  endtask

  task automatic fill_pat(input int n, input logic [7:0] pat);
    line_n = n;
    for (int i = 0; i < 200; i++) line_px[i] = 2'((pat >> (6 - 2 * (i % 4))) & 8'h03);
  endtask

  task automatic run_line(input bit gaps, input bit end_vblank);
    int i;
    PX_valid = 1'b0;
    PPU_MODE = 2'd2;
    tick();
    tick();
    PPU_MODE = 2'd3;
    tick();
    i = 0;
    while (i < line_n) begin
      if (gaps && $urandom_range(0, 3) == 0) PX_valid = 1'b0;
      else begin
        PX_valid = 1'b1;
        PX_OUT   = line_px[i];
        i++;
      end
      tick();
    end
    PX_valid = 1'b0;
    PX_OUT   = 2'd0;
    PPU_MODE = end_vblank ? 2'd1 : 2'd0;
    repeat (30) tick();
  endtask

  initial begin
    vt[0] = '{160, 8'hFF, 40, 39, 8'hFF};
    vt[1] = '{160, 8'h1B, 40, 39, 8'h1B};
    vt[2] = '{6,   8'h1B, 2,  1,  8'h10};
    vt[3] = '{168, 8'hE4, 40, 39, 8'hE4};
    vt[4] = '{1,   8'hC0, 1,  0,  8'hC0};
    vt[5] = '{3,   8'h9C, 1,  0,  8'h9C};
    vt[6] = '{0,   8'h00, 0,  0,  8'h00};
    vt[7] = '{161, 8'h27, 40, 39, 8'h27};
    vt[8] = '{159, 8'hFF, 40, 39, 8'hFC};

    rst = 1'b1; PX_OUT = 2'd0; PX_valid = 1'b0; PPU_MODE = 2'd0; BGP = 8'hE4; FB_READY = 1'b1;
    repeat (3) tick();
    cmp("reset FB_WR", FB_WR, 0);
    cmp("reset FB_ADDR", FB_ADDR, 0);
    cmp("reset FB_DATA", FB_DATA, 0);
    cmp("reset FRAME_DONE", FRAME_DONE, 0);
    cmp("reset OVERFLOW", OVERFLOW, 0);
    rst = 1'b0;
    tick();

    // Pixels before the first V_BLANK are discarded.
    fill_pat(12, 8'h1B);
    run_line(0, 0);
    cmp("unsync writes", wq.size(), 0);
    wq.delete();
    PPU_MODE = 2'd1;
    repeat (4) tick();
    cmp("sync frame_done", fd_cnt, 0);

    cur_y = 0;
    for (int i = 0; i < 9; i++) begin
      fill_pat(vt[i].n, vt[i].pat);
      run_line(0, 0);
      cmp($sformatf("vec%0d count", i), wq.size(), vt[i].exp_n);
      if (vt[i].exp_n > 0 && wq.size() > 0) begin
        cmp($sformatf("vec%0d last addr", i), 32'(wq[wq.size() - 1][20:8]), cur_y * 40 + vt[i].exp_off);
        cmp($sformatf("vec%0d last data", i), 32'(wq[wq.size() - 1][7:0]), vt[i].exp_d);
        cmp($sformatf("vec%0d first addr", i), 32'(wq[0][20:8]), cur_y * 40);
      end
      wq.delete();
      cur_y++;
    end

    // Fourth pixel of a group reaches FB_WR one cycle later with an empty FIFO.
    PPU_MODE = 2'd2; tick(); tick();
    PPU_MODE = 2'd3; tick();
    for (int k = 0; k < 4; k++) begin
      PX_valid = 1'b1;
      PX_OUT   = 2'(k);
      tick();
      if (k == 2) cmp("latency early FB_WR", FB_WR, 0);
    end
    cmp("latency FB_WR", FB_WR, 1);
    cmp("latency FB_ADDR", FB_ADDR, cur_y * 40);
    cmp("latency FB_DATA", FB_DATA, 8'h1B);
    PX_valid = 1'b0;
    PPU_MODE = 2'd0;
    repeat (20) tick();
    cmp("latency count", wq.size(), 1);
    wq.delete();
    cur_y++;

    // Backpressure: 40 stalled cycles overflow a 4-deep buffer.
    cmp("overflow before stall", OVERFLOW, 0);
    fill_pat(160, 8'hE4);
    PPU_MODE = 2'd2; tick(); tick();
    PPU_MODE = 2'd3; tick();
    FB_READY = 1'b0;
    for (int i = 0; i < 160; i++) begin
      if (i == 40) FB_READY = 1'b1;
      PX_valid = 1'b1;
      PX_OUT   = line_px[i];
      tick();
    end
    PX_valid = 1'b0;
    PPU_MODE = 2'd0;
    repeat (30) tick();
    cmp("stall OVERFLOW", OVERFLOW, 1);
    cmp("stall count", wq.size(), 34);
    if (wq.size() > 4) cmp("stall resume addr", 32'(wq[4][20:8]), cur_y * 40 + 10);
    if (wq.size() > 0) cmp("stall last addr", 32'(wq[wq.size() - 1][20:8]), cur_y * 40 + 39);
    wq.delete();
    cur_y++;

    // Random lines through the end of the frame, including two clipped surplus lines.
    rdy_rand = 1;
    while (cur_y < 146) begin
      if (cur_y == 143) line_n = 168;
      else if ($urandom_range(0, 1) == 1) line_n = $urandom_range(150, 168);
      else line_n = $urandom_range(0, 168);
      for (int i = 0; i < 200; i++) line_px[i] = 2'($urandom_range(0, 3));
      run_line(1, 0);
      model_line(cur_y, BGP);
      if (cur_y == 143)
        cmp("last fb addr", (wq.size() > 0) ? 32'(wq[wq.size() - 1][20:8]) : 32'd0, 5759);
      check_writes("rnd");
      cur_y++;
    end
    rdy_rand = 0;
    FB_READY = 1'b1;
    cmp("frame_done before vblank", fd_cnt, 0);
    PPU_MODE = 2'd1;
    repeat (10) tick();
    cmp("frame_done count", fd_cnt, 1);
    cmp("vblank writes", wq.size(), 0);
    wq.delete();

    // V_BLANK straight out of DRAW: partial byte flushed, then one FRAME_DONE.
    fd_cnt = 0;
    cur_y  = 0;
    line_n = 6;
    line_px[0] = 2'd3; line_px[1] = 2'd2; line_px[2] = 2'd1;
    line_px[3] = 2'd0; line_px[4] = 2'd2; line_px[5] = 2'd2;
    run_line(0, 1);
    model_line(0, BGP);
    check_writes("vblank-in-line");
    cmp("vblank-in-line frame_done", fd_cnt, 1);

    // Palette map: shade of index 1 under two BGP values.
    BGP = 8'h1B;
    fill_pat(4, 8'h55);
    run_line(0, 0);
    cmp("palette 1B count", wq.size(), 1);
`ifdef PX_PALETTE_EN
    if (wq.size() > 0) cmp("palette 1B data", 32'(wq[0][7:0]), 8'hAA);
`else
    if (wq.size() > 0) cmp("palette 1B data", 32'(wq[0][7:0]), 8'h55);
`endif
    if (wq.size() > 0) cmp("palette 1B addr", 32'(wq[0][20:8]), 0);
    wq.delete();
    BGP = 8'hE4;
    run_line(0, 0);
    cmp("palette E4 count", wq.size(), 1);
    if (wq.size() > 0) cmp("palette E4 data", 32'(wq[0][7:0]), 8'h55);
    if (wq.size() > 0) cmp("palette E4 addr", 32'(wq[0][20:8]), 40);
    wq.delete();

    // Reset mid-line with bytes queued: queue discarded, back to unsynced.
    FB_READY = 1'b0;
    PPU_MODE = 2'd2; tick();
    PPU_MODE = 2'd3; tick();
    for (int i = 0; i < 10; i++) begin
      PX_valid = 1'b1;
      PX_OUT   = 2'd3;
      tick();
    end
    cmp("pre-reset FB_WR", FB_WR, 1);
    rst = 1'b1;
    tick(); tick();
    cmp("midreset FB_WR", FB_WR, 0);
    cmp("midreset OVERFLOW", OVERFLOW, 0);
    cmp("midreset FB_ADDR", FB_ADDR, 0);
    rst = 1'b0;
    FB_READY = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    PX_valid = 1'b0;
    PPU_MODE = 2'd0;
    repeat (20) tick();
    cmp("post-reset writes", wq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
